// File: rtl/iso_pwr_seq_if.sv
// Bus between the power manager / switchable domains and iso_pwr_seq.
// Carries per-channel requests, switch status, domain data and sequencer outputs.
interface iso_pwr_seq_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned W   = 8
);
  logic [NCH-1:0]   dn_req;
  logic [NCH-1:0]   up_req;
  logic [NCH-1:0]   pwr_ack;
  logic [NCH*W-1:0] din;
  logic [NCH-1:0]   pwr_en;
  logic [NCH-1:0]   iso_b;
  logic [NCH*W-1:0] dout;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   err;

  modport master (
    output dn_req, up_req, pwr_ack, din,
    input  pwr_en, iso_b, dout, busy, err
  );

  modport slave (
    input  dn_req, up_req, pwr_ack, din,
    output pwr_en, iso_b, dout, busy, err
  );
endinterface

// File: rtl/iso_pwr_seq.sv
// Per-channel power-down/up sequencer with active-low isolation clamps on each domain bus.
// Optional ISO_HOLD_EN: isolated outputs hold the last valid value instead of clamping to 0.
module iso_pwr_seq #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned W       = 8,
  parameter int unsigned ISO_DLY = 2,
  parameter int unsigned PWR_TO  = 15
) (
  input logic         clk,
  input logic         rst_n,
  iso_pwr_seq_if.slave bus
);

  localparam int unsigned CNT_MAX = (ISO_DLY > PWR_TO) ? ISO_DLY : PWR_TO;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_ON       = 3'd0;
  localparam logic [2:0] S_ISO      = 3'd1;
  localparam logic [2:0] S_OFF_WAIT = 3'd2;
  localparam logic [2:0] S_OFF      = 3'd3;
  localparam logic [2:0] S_ON_WAIT  = 3'd4;
  localparam logic [2:0] S_SETTLE   = 3'd5;
  localparam logic [2:0] S_ERR      = 3'd6;

  logic [2:0]    state_q [NCH];
  logic [2:0]    state_d [NCH];
  logic [CW-1:0] cnt_q   [NCH];
  logic [CW-1:0] cnt_d   [NCH];
  logic [NCH-1:0] pwr_en_q, pwr_en_d;
  logic [NCH-1:0] iso_b_q,  iso_b_d;
  logic [NCH-1:0] busy_q,   busy_d;
  logic [NCH-1:0] err_q,    err_d;
  logic [NCH*W-1:0] dout_c;

  // Next state, counters and registered per-channel outputs (decoded from next state)
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwr_en_d = pwr_en_q;
    iso_b_d  = '0;
    busy_d   = '0;
    err_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      case (state_q[i])
        S_ON:       if (bus.dn_req[i]) state_d[i] = S_ISO;
        S_ISO:      if (cnt_q[i] == CW'(ISO_DLY - 1)) state_d[i] = S_OFF_WAIT;
        S_OFF_WAIT: begin
          if (!bus.pwr_ack[i])                    state_d[i] = S_OFF;
          else if (cnt_q[i] == CW'(PWR_TO - 1))   state_d[i] = S_ERR;
        end
        S_OFF:      if (bus.up_req[i]) state_d[i] = S_ON_WAIT;
        S_ON_WAIT: begin
          if (bus.pwr_ack[i])                     state_d[i] = S_SETTLE;
          else if (cnt_q[i] == CW'(PWR_TO - 1))   state_d[i] = S_ERR;
        end
        // losing pwr_ack while settling restarts the power-up wait
        S_SETTLE: begin
          if (!bus.pwr_ack[i])                    state_d[i] = S_ON_WAIT;
          else if (cnt_q[i] == CW'(ISO_DLY - 1))  state_d[i] = S_ON;
        end
        S_ERR: begin
          if (bus.up_req[i])      state_d[i] = S_ON_WAIT;
          else if (bus.dn_req[i]) state_d[i] = S_OFF_WAIT;
        end
        default:                  state_d[i] = S_ON_WAIT;
      endcase

      if (state_d[i] != state_q[i])         cnt_d[i] = '0;
      else if (cnt_q[i] != CW'(CNT_MAX))    cnt_d[i] = cnt_q[i] + CW'(1);

      case (state_d[i])
        S_ON:                   begin pwr_en_d[i] = 1'b1; iso_b_d[i] = 1'b1; end
        S_ISO:                  begin pwr_en_d[i] = 1'b1; busy_d[i] = 1'b1; end
        S_OFF_WAIT:             begin pwr_en_d[i] = 1'b0; busy_d[i] = 1'b1; end
        S_OFF:                        pwr_en_d[i] = 1'b0;
        S_ON_WAIT, S_SETTLE:    begin pwr_en_d[i] = 1'b1; busy_d[i] = 1'b1; end
        S_ERR:                        err_d[i]    = 1'b1;
        default:                      pwr_en_d[i] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_ON_WAIT;
        cnt_q[i]   <= '0;
      end
      pwr_en_q <= '1;
      iso_b_q  <= '0;
      busy_q   <= '1;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwr_en_q <= pwr_en_d;
      iso_b_q  <= iso_b_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

`ifdef ISO_HOLD_EN
  logic [NCH*W-1:0] hold_q, hold_d;

  // Track domain data only while it is known valid (not isolated)
  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < NCH; i++) begin
      if (iso_b_q[i]) hold_d[i*W +: W] = bus.din[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  always_comb begin
    dout_c = hold_q;
    for (int i = 0; i < NCH; i++) begin
      if (iso_b_q[i]) dout_c[i*W +: W] = bus.din[i*W +: W];
    end
  end
`else
  always_comb begin
    dout_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (iso_b_q[i]) dout_c[i*W +: W] = bus.din[i*W +: W];
    end
  end
`endif

  assign bus.pwr_en = pwr_en_q;
  assign bus.iso_b  = iso_b_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;
  assign bus.dout   = dout_c;

endmodule

// File: tb/tb_iso_pwr_seq.sv
// Directed bench for iso_pwr_seq (NCH=2, W=8, ISO_DLY=2, PWR_TO=15).
module tb_iso_pwr_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  iso_pwr_seq_if #(.NCH(2), .W(8)) bus ();

  iso_pwr_seq #(.NCH(2), .W(8), .ISO_DLY(2), .PWR_TO(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.dn_req  = 2'b00;
    bus.up_req  = 2'b00;
    bus.pwr_ack = 2'b11;
    bus.din     = 16'h3CA5;
    #2 rst_n = 1'b0;
    tick();
    tick();
    vecs++; if (bus.iso_b !== 2'b00)  begin errs++; $display("FAIL reset_iso_b got %b exp 00", bus.iso_b); end
    vecs++; if (bus.pwr_en !== 2'b11) begin errs++; $display("FAIL reset_pwr_en got %b exp 11", bus.pwr_en); end
    vecs++; if (bus.dout !== 16'h0)   begin errs++; $display("FAIL reset_dout got %h exp 0000", bus.dout); end
    vecs++; if (bus.busy !== 2'b11)   begin errs++; $display("FAIL reset_busy got %b exp 11", bus.busy); end
    vecs++; if (bus.err !== 2'b00)    begin errs++; $display("FAIL reset_err got %b exp 00", bus.err); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    vecs++; if (bus.iso_b !== 2'b00)  begin errs++; $display("FAIL release_iso_early got %b exp 00", bus.iso_b); end
    tick();
    vecs++; if (bus.iso_b !== 2'b11)  begin errs++; $display("FAIL release_iso_b got %b exp 11", bus.iso_b); end
    vecs++; if (bus.busy !== 2'b00)   begin errs++; $display("FAIL release_busy got %b exp 00", bus.busy); end
    vecs++; if (bus.dout !== 16'h3CA5) begin errs++; $display("FAIL release_dout got %h exp 3ca5", bus.dout); end
  endtask

  task automatic test_power_down();
    logic [7:0] exp_lo;
    bus.dn_req = 2'b01;
    tick();
    bus.dn_req = 2'b00;
    vecs++; if (bus.iso_b !== 2'b10)  begin errs++; $display("FAIL dn_iso_b got %b exp 10", bus.iso_b); end
    vecs++; if (bus.pwr_en !== 2'b11) begin errs++; $display("FAIL dn_pwr_en_hold got %b exp 11", bus.pwr_en); end
    vecs++; if (bus.busy !== 2'b01)   begin errs++; $display("FAIL dn_busy got %b exp 01", bus.busy); end
    tick();
    vecs++; if (bus.pwr_en !== 2'b11) begin errs++; $display("FAIL dn_pwr_en_early got %b exp 11", bus.pwr_en); end
    tick();
    vecs++; if (bus.pwr_en !== 2'b10) begin errs++; $display("FAIL dn_pwr_en_off got %b exp 10", bus.pwr_en); end
    tick();
    tick();
    tick();
    bus.pwr_ack = 2'b10;
    tick();
    vecs++; if (bus.busy !== 2'b00)   begin errs++; $display("FAIL off_busy got %b exp 00", bus.busy); end
    vecs++; if (bus.err !== 2'b00)    begin errs++; $display("FAIL off_err got %b exp 00", bus.err); end
    vecs++; if (bus.iso_b !== 2'b10)  begin errs++; $display("FAIL off_iso_b got %b exp 10", bus.iso_b); end
    vecs++; if (bus.dout[15:8] !== 8'h3C) begin errs++; $display("FAIL off_ch1_dout got %h exp 3c", bus.dout[15:8]); end
    bus.din[7:0] = 8'h5A;
    #1;
`ifdef ISO_HOLD_EN
    exp_lo = 8'hA5;
`else
    exp_lo = 8'h00;
`endif
    vecs++; if (bus.dout[7:0] !== exp_lo) begin errs++; $display("FAIL clamp_dout got %h exp %h", bus.dout[7:0], exp_lo); end
  endtask

  task automatic test_timeout();
    bus.up_req = 2'b01;
    tick();
    bus.up_req = 2'b00;
    for (int k = 1; k < 15; k++) tick();
    vecs++; if (bus.err !== 2'b00)    begin errs++; $display("FAIL to_err_early got %b exp 00", bus.err); end
    vecs++; if (bus.busy !== 2'b01)   begin errs++; $display("FAIL to_busy got %b exp 01", bus.busy); end
    tick();
    vecs++; if (bus.err !== 2'b01)    begin errs++; $display("FAIL to_err got %b exp 01", bus.err); end
    vecs++; if (bus.iso_b !== 2'b10)  begin errs++; $display("FAIL to_iso_b got %b exp 10", bus.iso_b); end
    vecs++; if (bus.pwr_en !== 2'b11) begin errs++; $display("FAIL to_pwr_en got %b exp 11", bus.pwr_en); end
    vecs++; if (bus.busy !== 2'b00)   begin errs++; $display("FAIL to_err_busy got %b exp 00", bus.busy); end
    bus.up_req = 2'b01;
    tick();
    bus.up_req  = 2'b00;
    bus.pwr_ack = 2'b11;
    vecs++; if (bus.err !== 2'b00)    begin errs++; $display("FAIL retry_err got %b exp 00", bus.err); end
    tick();
    tick();
    vecs++; if (bus.iso_b !== 2'b10)  begin errs++; $display("FAIL retry_iso_early got %b exp 10", bus.iso_b); end
    tick();
    vecs++; if (bus.iso_b !== 2'b11)  begin errs++; $display("FAIL retry_iso_b got %b exp 11", bus.iso_b); end
    vecs++; if (bus.dout !== 16'h3C5A) begin errs++; $display("FAIL retry_dout got %h exp 3c5a", bus.dout); end
  endtask

  task automatic test_settle_ignore();
    rst_n = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    bus.dn_req = 2'b11;
    tick();
    bus.dn_req = 2'b00;
    tick();
    vecs++; if (bus.iso_b !== 2'b11)  begin errs++; $display("FAIL settle_drop_iso got %b exp 11", bus.iso_b); end
    vecs++; if (bus.busy !== 2'b00)   begin errs++; $display("FAIL settle_drop_busy got %b exp 00", bus.busy); end
    bus.dn_req = 2'b01;
    bus.up_req = 2'b01;
    tick();
    bus.dn_req = 2'b00;
    bus.up_req = 2'b00;
    vecs++; if (bus.iso_b !== 2'b10)  begin errs++; $display("FAIL both_req_iso got %b exp 10", bus.iso_b); end
    vecs++; if (bus.busy !== 2'b01)   begin errs++; $display("FAIL both_req_busy got %b exp 01", bus.busy); end
  endtask

  task automatic test_async_reset();
    bus.dn_req = 2'b10;
    tick();
    bus.dn_req = 2'b00;
    tick();
    tick();
    vecs++; if (bus.pwr_en[1] !== 1'b0) begin errs++; $display("FAIL offwait_pwr_en1 got %b exp 0", bus.pwr_en[1]); end
    vecs++; if (bus.busy[1] !== 1'b1)   begin errs++; $display("FAIL offwait_busy1 got %b exp 1", bus.busy[1]); end
    #1 rst_n = 1'b0;
    #1;
    vecs++; if (bus.pwr_en !== 2'b11) begin errs++; $display("FAIL arst_pwr_en got %b exp 11", bus.pwr_en); end
    vecs++; if (bus.iso_b !== 2'b00)  begin errs++; $display("FAIL arst_iso_b got %b exp 00", bus.iso_b); end
    vecs++; if (bus.busy !== 2'b11)   begin errs++; $display("FAIL arst_busy got %b exp 11", bus.busy); end
    vecs++; if (bus.dout !== 16'h0)   begin errs++; $display("FAIL arst_dout got %h exp 0000", bus.dout); end
  endtask

  initial begin
    test_reset();
    test_power_down();
    test_timeout();
    test_settle_ignore();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
